// File: rtl/rgb_led_pkg.sv
// Shared types and helpers for the RGB breathing LED stage: FSM states,
// colour indices, colour masks and the pin polarity of the board LED.
package rgb_led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD_TOP,
        ST_RAMP_DOWN,
        ST_HOLD_BOT
    } state_e;

    localparam logic [1:0] COLOR_R = 2'd0;
    localparam logic [1:0] COLOR_G = 2'd1;
    localparam logic [1:0] COLOR_B = 2'd2;
    localparam logic [1:0] COLOR_W = 2'd3;

    // The iCEBreaker++ RGB LED sinks current: a 0 on the pin lights it.
    localparam logic       LED_ACTIVE_LOW = 1'b1;
    localparam logic [2:0] RGB_OFF        = {3{LED_ACTIVE_LOW}};

    // Channel enables in {R,G,B} order for a colour index.
    function automatic logic [2:0] color_mask(input logic [1:0] idx);
        logic [2:0] mask;
        case (idx)
            COLOR_R: mask = 3'b100;
            COLOR_G: mask = 3'b010;
            COLOR_B: mask = 3'b001;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    // Map {R,G,B} "on" flags onto the pin order {red, blue, green} with polarity.
    function automatic logic [2:0] drive_pins(input logic [2:0] on_rgb);
        return {on_rgb[2], on_rgb[0], on_rgb[1]} ^ RGB_OFF;
    endfunction

endpackage

// File: rtl/pwm_compare.sv
// Free-running PWM counter and registered, mask-gated comparator driving the
// three LED pins with the board's active-low polarity.
module pwm_compare
    import rgb_led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [2:0]          mask_i,
    output logic [2:0]          rgb_o
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [2:0]          rgb_q;
    logic [2:0]          rgb_d;
    logic                lit;

    always_comb begin
        lit   = (pwm_cnt_q < duty_i);
        rgb_d = drive_pins(mask_i & {3{lit}});
    end

    // NOTE: sequential state uses non-blocking assignments only, and every
    // register here sits in the asynchronous reset branch so the pins go dark
    // the instant reset rises, without waiting for a clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pwm_cnt_q <= '0;
            rgb_q     <= RGB_OFF;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/rgb_breathe_pwm.sv
// Breathing LED sequencer: a prescaled step tick ramps a shared duty up and
// down while an FSM walks the colours R, G, B, W; pwm_compare drives the pins.
module rgb_breathe_pwm
    import rgb_led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 4096,
    parameter int HOLD_STEPS  = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                en,
    output logic [2:0]          rgb,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          color_idx,
    output logic                cycle_done
);

    localparam int PRE_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int HOLD_W = $clog2(HOLD_STEPS + 1);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] DMAX      = '1;
    localparam logic [PWM_BITS-1:0] DMAX_M1   = DMAX - 1'b1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    state_e              state_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [1:0]          color_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                done_q;

    logic [PRE_W-1:0]    pre_cnt_q;
    logic [PRE_W-1:0]    pre_cnt_d;
    logic                running;
    logic                step_tick;
    logic [2:0]          pwm_rgb;

    // The prescaler only advances once the FSM has left IDLE, and en gates the
    // tick itself so a tick coinciding with en falling is simply not taken.
    assign running   = en && (state_q != ST_IDLE);
    assign step_tick = running && (pre_cnt_q == PRE_LAST);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (running) begin
            pre_cnt_d = step_tick ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            color_q <= COLOR_R;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_RAMP_UP;
                        duty_q  <= '0;
                        color_q <= COLOR_R;
                        hold_q  <= '0;
                    end
                    ST_RAMP_UP: begin
                        if (step_tick) begin
                            duty_q <= duty_q + DUTY_ONE;
                            if (duty_q == DMAX_M1) begin
                                state_q <= ST_HOLD_TOP;
                                hold_q  <= '0;
                            end
                        end
                    end
                    ST_HOLD_TOP: begin
                        if (step_tick) begin
                            hold_q <= hold_q + 1'b1;
                            if (hold_q == HOLD_LAST) begin
                                state_q <= ST_RAMP_DOWN;
                            end
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (step_tick) begin
                            duty_q <= duty_q - DUTY_ONE;
                            if (duty_q == DUTY_ONE) begin
                                state_q <= ST_HOLD_BOT;
                                hold_q  <= '0;
                            end
                        end
                    end
                    ST_HOLD_BOT: begin
                        if (step_tick) begin
                            hold_q <= hold_q + 1'b1;
                            if (hold_q == HOLD_LAST) begin
                                state_q <= ST_RAMP_UP;
                                color_q <= color_q + 1'b1;
                                done_q  <= (color_q == COLOR_W);
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    pwm_compare #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .duty_i (duty_q),
        .mask_i (color_mask(color_q)),
        .rgb_o  (pwm_rgb)
    );

    // NOTE: the pause blanking is applied after the pin register so the LED
    // goes dark in the same cycle en drops; the compare path stays registered.
    assign rgb        = en ? pwm_rgb : RGB_OFF;
    assign duty       = duty_q;
    assign color_idx  = color_q;
    assign cycle_done = done_q;

    a_duty_saturates: assert property (@(posedge clk_in) disable iff (rst_in)
        !(step_tick && (((state_q == ST_RAMP_UP) && (duty_q == DMAX)) ||
                        ((state_q == ST_RAMP_DOWN) && (duty_q == '0)))));

endmodule
